// File: rtl/simd_bridge_pkg.sv
// simd_bridge_pkg: shared state encoding and sizes for the SIMD host bridge
package simd_bridge_pkg;
    localparam int IOSIZE = 16;
    localparam int WORDSIZE = 32;
    localparam int DEF_TIMEOUT = 255;
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_GET, S_LOAD_HI, S_LOAD_LO, S_FETCH_HI, S_FETCH_LO, S_PUSH, S_ERR
    } state_t;
    function automatic logic is_wait(state_t s);
        return s inside {S_LOAD_HI, S_LOAD_LO, S_FETCH_HI, S_FETCH_LO};
    endfunction
endpackage

// File: rtl/simd_ack_timer.sv
// simd_ack_timer: counts cycles without ack and flags the TIMEOUT-th one
module simd_ack_timer import simd_bridge_pkg::*; #(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (tick) cnt <= cnt + 8'd1;
    assign expired = tick && (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/simd_host_bridge.sv
// simd_host_bridge: streams host operands into simd_top halfword by halfword and returns fetched results
module simd_host_bridge import simd_bridge_pkg::*; #(
    parameter int FETCH_WORDS = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORDSIZE-1:0] s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WORDSIZE-1:0] m_data,
    output logic                init,
    output logic                load,
    output logic                fetch,
    output logic [IOSIZE-1:0]   idata,
    input  logic                ack,
    input  logic [IOSIZE-1:0]   odata,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_t state, state_n;
    logic [IOSIZE-1:0] lat_lo;
    logic lat_last, load_hold, tick, expired;
    logic [7:0] fetch_cnt, cnt_inc;
    assign cnt_inc = fetch_cnt + 8'd1;
    assign tick = is_wait(state) && !ack;
    simd_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .clear(state_n != state),
        .tick(tick),
        .expired(expired)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_ERR: state_n = start ? S_INIT : state;
            S_INIT:        state_n = S_GET;
            S_GET:         state_n = s_valid ? S_LOAD_HI : state;
            S_LOAD_HI:     state_n = ack ? S_LOAD_LO : expired ? S_ERR : state;
            S_LOAD_LO:     state_n = ack ? (lat_last ? S_FETCH_HI : S_GET) : expired ? S_ERR : state;
            S_FETCH_HI:    state_n = ack ? S_FETCH_LO : expired ? S_ERR : state;
            S_FETCH_LO:    state_n = ack ? S_PUSH : expired ? S_ERR : state;
            S_PUSH:        state_n = !m_ready ? state : (cnt_inc < 8'(FETCH_WORDS)) ? S_FETCH_HI : S_IDLE;
            default:       state_n = S_IDLE;
        endcase
    end
    // load also covers GET between words of a job so simd_top sees one unbroken load burst
    always_comb begin
        init = state == S_INIT;
        s_ready = state == S_GET;
        load = (state inside {S_LOAD_HI, S_LOAD_LO}) || (state == S_GET && load_hold);
        fetch = state inside {S_FETCH_HI, S_FETCH_LO};
        m_valid = state == S_PUSH;
        busy = !(state inside {S_IDLE, S_ERR});
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            done <= 1'b0;
            err <= 1'b0;
            fetch_cnt <= '0;
            idata <= '0;
            lat_lo <= '0;
            lat_last <= 1'b0;
            load_hold <= 1'b0;
            m_data <= '0;
        end else begin
            done <= state == S_PUSH && m_ready && state_n == S_IDLE;
            if ((state == S_IDLE || state == S_ERR) && start) begin
                err <= 1'b0;
                fetch_cnt <= '0;
            end
            if (expired) err <= 1'b1;
            if (state == S_GET && s_valid) begin
                idata <= s_data[WORDSIZE-1:IOSIZE];
                lat_lo <= s_data[IOSIZE-1:0];
                lat_last <= s_last;
            end
            if (state == S_LOAD_HI && ack) idata <= lat_lo;
            load_hold <= state == S_INIT ? 1'b0 : (state == S_LOAD_LO && ack) ? !lat_last : load_hold;
            if (state == S_FETCH_HI && ack) m_data[WORDSIZE-1:IOSIZE] <= odata;
            if (state == S_FETCH_LO && ack) m_data[IOSIZE-1:0] <= odata;
            if (state == S_PUSH && m_ready) fetch_cnt <= cnt_inc;
        end
endmodule
